// File: rtl/stop_watch_pkg.sv
// Purpose : shared state encoding and field widths for the stop-watch control path.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package stop_watch_pkg;

  localparam int MIN_W  = 7;
  localparam int SEC_W  = 7;
  localparam int MSEC_W = 10;
  localparam int LAP_W  = 7;

  // Codes are visible on the debug/LED state port, so keep them fixed.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    LAP   = 3'd2,
    PAUSE = 3'd3,
    CLEAR = 3'd4
  } state_t;

endpackage

// File: rtl/stop_watch_ctrl_btn_edge.sv
// Purpose : 2-flop synchronizer for a raw button level plus a rising-edge one-cycle pulse.
// Latency : pulse is high the cycle after the level reaches sync stage 2 (2 clocks from first capture).
// Backpressure: none; a held button yields exactly one pulse.
// Ports: clk, rst (async active-low), btn (raw level), pulse (one-cycle press strobe).
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Only the synchronized level is compared, so metastability never reaches the FSM.
  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/stop_watch_ctrl.sv
// Purpose : start/pause/lap/clear sequencer driving stop_watch enable/zero and the display mux.
// Latency : state changes 2 clocks after a button level is first captured; disp_* is combinational.
// Backpressure: none; presses arriving while a transition is not allowed are dropped.
// Ports: clk, rst (async active-low), btn_ss/btn_lr (raw buttons), min/sec/msec (live count),
//        enable/zero (to stop_watch), disp_* (to display), frozen, lap_cnt, state (debug/LEDs).
// Build option: define STOP_WATCH_LAP_EN to include the LAP state and snapshot registers.
module stop_watch_ctrl
  import stop_watch_pkg::*;
#(
  parameter int LAP_MAX = 99
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_ss,
  input  logic              btn_lr,
  input  logic [MIN_W-1:0]  min,
  input  logic [SEC_W-1:0]  sec,
  input  logic [MSEC_W-1:0] msec,
  output logic              enable,
  output logic              zero,
  output logic [MIN_W-1:0]  disp_min,
  output logic [SEC_W-1:0]  disp_sec,
  output logic [MSEC_W-1:0] disp_msec,
  output logic              frozen,
  output logic [LAP_W-1:0]  lap_cnt,
  output logic [2:0]        state
);

  logic             ss_p;
  logic             lr_p;
  state_t           state_q;
  state_t           state_d;
  logic             snap_take;
  logic [LAP_W-1:0] lap_q;

  btn_edge u_ss (.clk(clk), .rst(rst), .btn(btn_ss), .pulse(ss_p));
  btn_edge u_lr (.clk(clk), .rst(rst), .btn(btn_lr), .pulse(lr_p));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // ss_p is always tested first, so a simultaneous lr_p is simply dropped.
  always_comb begin
    state_d   = state_q;
    snap_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (ss_p) state_d = RUN;
      end
      RUN: begin
        if (ss_p) state_d = PAUSE;
`ifdef STOP_WATCH_LAP_EN
        else if (lr_p) begin
          state_d   = LAP;
          snap_take = 1'b1;
        end
`endif
      end
`ifdef STOP_WATCH_LAP_EN
      LAP: begin
        if (ss_p) state_d = PAUSE;
        else if (lr_p) begin
          state_d   = LAP;
          snap_take = 1'b1;
        end
      end
`endif
      PAUSE: begin
        if (ss_p)      state_d = RUN;
        else if (lr_p) state_d = CLEAR;
      end
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Without the lap feature snap_take is constant 0, so this counter stays at 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q <= '0;
    end else if (state_q == CLEAR) begin
      lap_q <= '0;
    end else if (snap_take && (lap_q != LAP_W'(LAP_MAX))) begin
      lap_q <= lap_q + LAP_W'(1);
    end
  end

`ifdef STOP_WATCH_LAP_EN
  logic [MIN_W-1:0]  snap_min;
  logic [SEC_W-1:0]  snap_sec;
  logic [MSEC_W-1:0] snap_msec;

  // Captured on the edge entering LAP, i.e. the counter value before its increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_min  <= '0;
      snap_sec  <= '0;
      snap_msec <= '0;
    end else if (snap_take) begin
      snap_min  <= min;
      snap_sec  <= sec;
      snap_msec <= msec;
    end
  end

  assign frozen    = (state_q == LAP);
  assign disp_min  = frozen ? snap_min  : min;
  assign disp_sec  = frozen ? snap_sec  : sec;
  assign disp_msec = frozen ? snap_msec : msec;
`else
  assign frozen    = 1'b0;
  assign disp_min  = min;
  assign disp_sec  = sec;
  assign disp_msec = msec;
`endif

  assign enable  = (state_q == RUN) || (state_q == LAP);
  assign zero    = (state_q == CLEAR);
  assign lap_cnt = lap_q;
  assign state   = state_q;

endmodule
